clkbuf_div_gate: RTL and testbench



---
 rtl/clkbuf_div_gate.sv | 110 +++++++++++
 tb/tb_clkbuf_div_gate.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/clkbuf_div_gate.sv
// Multi-channel 50%-duty clock divider with glitch-free per-channel enable and global ALIGN.
// Optional macro CLKBUF_DIV_GATE_ENSYNC_EN adds a 2-flop synchroniser on every EN bit.
module clkbuf_div_gate #(
    parameter int NCH  = 4,
    parameter int DIVW = 4
) (
    input  logic                 CLK,
    input  logic                 RN,
    input  logic [NCH-1:0]       EN,
    input  logic [NCH*DIVW-1:0]  DIV,
    input  logic                 ALIGN,
    output logic [NCH-1:0]       Z,
    output logic [NCH-1:0]       ACTIVE
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    logic [NCH-1:0] en_eff;

`ifdef CLKBUF_DIV_GATE_ENSYNC_EN
    logic [NCH-1:0] en_meta_p0;
    logic [NCH-1:0] en_sync_p1;

    // EN synchroniser: two flops, cleared by RN
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            en_meta_p0 <= '0;
            en_sync_p1 <= '0;
        end else begin
            en_meta_p0 <= EN;
            en_sync_p1 <= en_meta_p0;
        end
    end

    assign en_eff = en_sync_p1;
`else
    assign en_eff = EN;
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        state_t            st;
        state_t            st_nxt;
        logic [DIVW-1:0]   cnt;
        logic [DIVW-1:0]   cnt_nxt;
        logic [DIVW-1:0]   div_q;
        logic [DIVW-1:0]   div_q_nxt;
        logic [DIVW-1:0]   div_in;
        logic              z;
        logic              z_nxt;

        assign div_in = DIV[i*DIVW +: DIVW];

        always_ff @(posedge CLK or negedge RN) begin
            if (!RN) begin
                st    <= IDLE;
                cnt   <= '0;
                div_q <= '0;
                z     <= 1'b0;
            end else begin
                st    <= st_nxt;
                cnt   <= cnt_nxt;
                div_q <= div_q_nxt;
                z     <= z_nxt;
            end
        end

        always_comb begin
            st_nxt    = st;
            cnt_nxt   = cnt;
            div_q_nxt = div_q;
            z_nxt     = z;
            case (st)
                IDLE: begin
                    cnt_nxt = '0;
                    z_nxt   = 1'b0;
                    if (en_eff[i]) begin
                        z_nxt     = 1'b1;
                        div_q_nxt = div_in;
                        st_nxt    = RUN;
                    end
                end
                RUN: begin
                    // ALIGN restarts a high phase only for channels still requested to run
                    if (ALIGN && en_eff[i]) begin
                        z_nxt     = 1'b1;
                        cnt_nxt   = '0;
                        div_q_nxt = div_in;
                    end else if (cnt != div_q) begin
                        cnt_nxt = cnt + DIVW'(1);
                    end else if (z) begin
                        z_nxt   = 1'b0;
                        cnt_nxt = '0;
                    end else if (en_eff[i]) begin
                        z_nxt     = 1'b1;
                        cnt_nxt   = '0;
                        div_q_nxt = div_in;
                    end else begin
                        st_nxt  = IDLE;
                        cnt_nxt = '0;
                    end
                end
                default: st_nxt = IDLE;
            endcase
        end

        assign Z[i]      = z;
        assign ACTIVE[i] = (st == RUN);
    end

endmodule

// File: tb/tb_clkbuf_div_gate.sv
// Directed, table-driven bench for clkbuf_div_gate (NCH=4, DIVW=4), including the ENSYNC build.
module tb_clkbuf_div_gate;

`ifdef CLKBUF_DIV_GATE_ENSYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    typedef struct {
        logic [3:0]  en;
        logic [15:0] div;
        logic        align;
        logic [3:0]  z;
        logic [3:0]  act;
    } vec_t;

    logic        clk = 1'b0;
    logic        rn = 1'b0;
    logic [3:0]  en = '0;
    logic [15:0] div = '0;
    logic        align = 1'b0;
    logic [3:0]  z;
    logic [3:0]  active;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t tbl[64];
    int   n_rows = 0;

    clkbuf_div_gate #(.NCH(4), .DIVW(4)) dut (
        .CLK(clk), .RN(rn), .EN(en), .DIV(div), .ALIGN(align),
        .Z(z), .ACTIVE(active)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act_v, input logic [3:0] exp_v);
        n_cmp++;
        if (act_v !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act_v, exp_v, $time);
        end
    endtask

    task automatic add(input logic [3:0] e, input logic [15:0] d, input logic a,
                       input logic [3:0] ez, input logic [3:0] ea);
        tbl[n_rows] = '{en: e, div: d, align: a, z: ez, act: ea};
        n_rows++;
    endtask

    task automatic run_rows(input int first, input int last, input string tag);
        for (int r = first; r < last; r++) begin
            en    = tbl[r].en;
            div   = tbl[r].div;
            align = tbl[r].align;
            @(negedge clk);
            check($sformatf("%s_z_row%0d", tag, r - first), z, tbl[r].z);
            check($sformatf("%s_act_row%0d", tag, r - first), active, tbl[r].act);
        end
        align = 1'b0;
    endtask

    // Hold the starting EN for the synchroniser latency; outputs must stay idle meanwhile
    task automatic prime(input logic [3:0] e, input logic [15:0] d, input string tag);
        en  = e;
        div = d;
        for (int k = 0; k < LAT; k++) begin
            @(negedge clk);
            check($sformatf("%s_latency_z%0d", tag, k), z, 4'b0000);
        end
    endtask

    task automatic do_reset();
        en = '0; div = '0; align = 1'b0;
        rn = 1'b0;
        repeat (2) @(negedge clk);
        rn = 1'b1;
    endtask

    int t_ratio, t_divchg, t_stop, t_align;

    initial begin
        // Ratios: ch0 DIV=0 (period 2), ch1 DIV=2 (period 6)
        t_ratio = n_rows;
        for (int p = 0; p < 2; p++) begin
            add(4'b0011, 16'h0020, 1'b0, 4'b0011, 4'b0011);
            add(4'b0011, 16'h0020, 1'b0, 4'b0010, 4'b0011);
            add(4'b0011, 16'h0020, 1'b0, 4'b0011, 4'b0011);
            add(4'b0011, 16'h0020, 1'b0, 4'b0000, 4'b0011);
            add(4'b0011, 16'h0020, 1'b0, 4'b0001, 4'b0011);
            add(4'b0011, 16'h0020, 1'b0, 4'b0000, 4'b0011);
        end
        // DIV 2->0 one cycle after the rise: 3 high, 3 low, then period 2
        t_divchg = n_rows;
        add(4'b0001, 16'h0002, 1'b0, 4'b0001, 4'b0001);
        add(4'b0001, 16'h0000, 1'b0, 4'b0001, 4'b0001);
        add(4'b0001, 16'h0000, 1'b0, 4'b0001, 4'b0001);
        add(4'b0001, 16'h0000, 1'b0, 4'b0000, 4'b0001);
        add(4'b0001, 16'h0000, 1'b0, 4'b0000, 4'b0001);
        add(4'b0001, 16'h0000, 1'b0, 4'b0000, 4'b0001);
        add(4'b0001, 16'h0000, 1'b0, 4'b0001, 4'b0001);
        add(4'b0001, 16'h0000, 1'b0, 4'b0000, 4'b0001);
        add(4'b0001, 16'h0000, 1'b0, 4'b0001, 4'b0001);
        add(4'b0001, 16'h0000, 1'b0, 4'b0000, 4'b0001);
        // Glitch-free stop, DIV=3, EN drops one cycle after the rise
        t_stop = n_rows;
        add(4'b0001, 16'h0003, 1'b0, 4'b0001, 4'b0001);
        for (int k = 0; k < 3; k++) add(4'b0000, 16'h0003, 1'b0, 4'b0001, 4'b0001);
        for (int k = 0; k < 4; k++) add(4'b0000, 16'h0003, 1'b0, 4'b0000, 4'b0001);
        for (int k = 0; k < 5; k++) add(4'b0000, 16'h0003, 1'b0, 4'b0000, 4'b0000);
        // ALIGN: ch0 DIV=1, ch1 DIV=3, both rise together then keep their own periods
        t_align = n_rows;
        add(4'b0011, 16'h0031, 1'b1, 4'b0011, 4'b0011);
        add(4'b0011, 16'h0031, 1'b0, 4'b0011, 4'b0011);
        add(4'b0011, 16'h0031, 1'b0, 4'b0010, 4'b0011);
        add(4'b0011, 16'h0031, 1'b0, 4'b0010, 4'b0011);
        add(4'b0011, 16'h0031, 1'b0, 4'b0001, 4'b0011);
        add(4'b0011, 16'h0031, 1'b0, 4'b0001, 4'b0011);
        add(4'b0011, 16'h0031, 1'b0, 4'b0000, 4'b0011);
        add(4'b0011, 16'h0031, 1'b0, 4'b0000, 4'b0011);
        add(4'b0011, 16'h0031, 1'b0, 4'b0011, 4'b0011);

        // Reset state
        rn = 1'b0;
        #2;
        check("reset_z", z, 4'b0000);
        check("reset_active", active, 4'b0000);
        do_reset();
        @(negedge clk);
        check("post_reset_z", z, 4'b0000);

        prime(4'b0011, 16'h0020, "ratio");
        run_rows(t_ratio, t_divchg, "ratio");

        do_reset();
        prime(4'b0001, 16'h0002, "divchg");
        run_rows(t_divchg, t_stop, "divchg");

        do_reset();
        prime(4'b0001, 16'h0003, "stop");
        run_rows(t_stop, t_align, "stop");

        // Start ch1 first, ch0 a few cycles later so phases differ before ALIGN
        do_reset();
        en = 4'b0010; div = 16'h0031;
        repeat (3 + LAT) @(negedge clk);
        en = 4'b0011;
        repeat (2 + LAT) @(negedge clk);
        check("align_pre_active", active, 4'b0011);
        run_rows(t_align, n_rows, "align");

        // Asynchronous reset mid-run while Z is high
        do_reset();
        en = 4'b0001; div = 16'h0005;
        repeat (1 + LAT) @(negedge clk);
        check("async_pre_z", z, 4'b0001);
        #2;
        rn = 1'b0;
        #1;
        check("async_z", z, 4'b0000);
        check("async_active", active, 4'b0000);
        en = 4'b0000;
        @(negedge clk);
        rn = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check($sformatf("idle_after_reset_%0d", k), z | active, 4'b0000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
